// File: rtl/bus_ctrl_pkg.sv
// Shared encodings for the register-bus transfer arbiter: FSM states,
// source/destination select codes and the default bus width.
package bus_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_DRIVE   = 2'b01;
  localparam logic [1:0] ST_WRITE   = 2'b10;
  localparam logic [1:0] ST_RELEASE = 2'b11;

  localparam logic [1:0] SRC_IN = 2'd0;
  localparam logic [1:0] SRC_R1 = 2'd1;
  localparam logic [1:0] SRC_R2 = 2'd2;
  localparam logic [1:0] SRC_R3 = 2'd3;

  localparam logic [1:0] DST_NONE = 2'd0;
  localparam logic [1:0] DST_R1   = 2'd1;
  localparam logic [1:0] DST_R2   = 2'd2;
  localparam logic [1:0] DST_R3   = 2'd3;

  // One-hot decode of a requester index; index 3 is unused and maps to none.
  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    logic [2:0] oh;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // Next requester index in the 0 -> 1 -> 2 -> 0 ring.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational round-robin picker: scans requesters ptr+1, ptr+2, ptr (mod 3).
module bus_rr_pick
  import bus_ctrl_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] winner,
  output logic       valid
);

  logic [1:0] cand;

  always_comb begin
    winner = 2'd0;
    valid  = 1'b0;
    cand   = rr_next(ptr);
    for (int k = 0; k < 3; k++) begin
      if (!valid && req[cand]) begin
        winner = cand;
        valid  = 1'b1;
      end
      cand = rr_next(cand);
    end
  end

endmodule

// File: rtl/bus_transfer_arbiter.sv
// Round-robin sequencer for the shared register bus: grants one of three
// requesters, moves data_in or a register onto the bus and into a register.
module bus_transfer_arbiter
  import bus_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic [2:0]       req,
  input  logic [5:0]       src,
  input  logic [5:0]       dst,
  output logic [2:0]       gnt,
  output logic [2:0]       ack,
  output logic [WIDTH-1:0] data_out,
  output logic [1:0]       state,
  output logic [WIDTH-1:0] Reg1,
  output logic [WIDTH-1:0] Reg2,
  output logic [WIDTH-1:0] Reg3
);

  logic [1:0]       state_q, state_d;
  logic [1:0]       winner_q, winner_d;
  logic [1:0]       src_q, src_d;
  logic [1:0]       dst_q, dst_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [2:0]       gnt_q, gnt_d;
  logic [2:0]       ack_q, ack_d;
  logic [WIDTH-1:0] r1_q, r1_d;
  logic [WIDTH-1:0] r2_q, r2_d;
  logic [WIDTH-1:0] r3_q, r3_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] bus_c;
  logic [1:0]       pick_winner;
  logic             pick_valid;

  bus_rr_pick u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  // Bus mux reads pre-edge register values; no write-through bypass.
  always_comb begin
    case (src_q)
      SRC_R1:  bus_c = r1_q;
      SRC_R2:  bus_c = r2_q;
      SRC_R3:  bus_c = r3_q;
      default: bus_c = data_in;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    src_d    = src_q;
    dst_d    = dst_q;
    ptr_d    = ptr_q;
    r1_d     = r1_q;
    r2_d     = r2_q;
    r3_d     = r3_q;
    dout_d   = dout_q;
    gnt_d    = 3'b000;
    ack_d    = 3'b000;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          winner_d = pick_winner;
          case (pick_winner)
            2'd1:    begin src_d = src[3:2]; dst_d = dst[3:2]; end
            2'd2:    begin src_d = src[5:4]; dst_d = dst[5:4]; end
            default: begin src_d = src[1:0]; dst_d = dst[1:0]; end
          endcase
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: state_d = ST_WRITE;
      ST_WRITE: begin
        case (dst_q)
          DST_R1:  r1_d = bus_c;
          DST_R2:  r2_d = bus_c;
          DST_R3:  r3_d = bus_c;
          default: ;
        endcase
        dout_d  = bus_c;
        ptr_d   = winner_q;
        state_d = ST_RELEASE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Grant/ack registered from the next state so they line up with state.
    if (state_d == ST_DRIVE || state_d == ST_WRITE) gnt_d = onehot3(winner_d);
    if (state_d == ST_RELEASE)                      ack_d = onehot3(winner_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      winner_q <= 2'd0;
      src_q    <= 2'd0;
      dst_q    <= 2'd0;
      ptr_q    <= 2'd2;
      gnt_q    <= 3'b000;
      ack_q    <= 3'b000;
      r1_q     <= '0;
      r2_q     <= '0;
      r3_q     <= '0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      r1_q     <= r1_d;
      r2_q     <= r2_d;
      r3_q     <= r3_d;
      dout_q   <= dout_d;
    end
  end

  assign state    = state_q;
  assign gnt      = gnt_q;
  assign ack      = ack_q;
  assign data_out = dout_q;
  assign Reg1     = r1_q;
  assign Reg2     = r2_q;
  assign Reg3     = r3_q;

endmodule
